// File: rtl/vga_sync_if.sv
// Sync inputs and recovered pixel-position outputs of the VGA receive path.
// The master drives hsync/vsync; the slave recovers the pixel position.
interface vga_sync_if;
    logic       hsync;
    logic       vsync;
    logic [9:0] x;
    logic [9:0] y;
    logic       active;
    logic       line_start;
    logic       frame_start;
    logic       locked;
    logic       err;

    modport master (
        output hsync, vsync,
        input  x, y, active, line_start, frame_start, locked, err
    );

    modport slave (
        input  hsync, vsync,
        output x, y, active, line_start, frame_start, locked, err
    );
endinterface

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates, strobes and lock status from incoming VGA hsync/vsync.
//   state  | meaning
//   SEARCH | no timing reference, waiting for a vsync fall
//   TRACK  | counting consecutive good frames toward lock
//   LOCKED | timing verified, coordinates and strobes valid
module vga_sync_decoder #(
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int LOCK_FRAMES = 2
) (
    input logic         clk,
    input logic         rst_n,
    vga_sync_if.slave   vif
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int GW      = $clog2(LOCK_FRAMES + 1);
    localparam logic [9:0] CNT_MAX = 10'd1023;
    localparam logic [9:0] H_ACT_LO = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_ACT_HI = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [9:0] V_ACT_LO = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_ACT_HI = 10'(V_SYNC + V_BP + V_ACTIVE - 1);

    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

    state_t         state, state_nxt;
    logic           hs_q, vs_q;
    logic [9:0]     h_cnt, v_cnt, h_cnt_nxt, v_cnt_nxt;
    logic [GW-1:0]  good, good_nxt;
    logic           frame_bad, frame_bad_nxt;
    logic           hs_fall, vs_fall;
    logic           line_err, frame_err, frame_good, sync_lost, any_err;
    logic           err_nxt, line_start_nxt, frame_start_nxt, active_nxt;
    logic [9:0]     x_nxt, y_nxt;

    always_comb begin
        hs_fall = hs_q & ~vif.hsync;
        vs_fall = vs_q & ~vif.vsync;

        if (hs_fall)
            h_cnt_nxt = 10'd0;
        else if (h_cnt != CNT_MAX)
            h_cnt_nxt = h_cnt + 10'd1;
        else
            h_cnt_nxt = h_cnt;

        if (vs_fall)
            v_cnt_nxt = 10'd0;
        else if (hs_fall && (v_cnt != CNT_MAX))
            v_cnt_nxt = v_cnt + 10'd1;
        else
            v_cnt_nxt = v_cnt;

        line_err   = hs_fall && (h_cnt != 10'(H_TOTAL - 1)) && (state != SEARCH);
        // a coincident hsync fall belongs to the closing frame, so it is added once here
        frame_err  = vs_fall && (({1'b0, v_cnt} + {10'd0, hs_fall}) != 11'(V_TOTAL));
        frame_good = vs_fall && !frame_err && !frame_bad && !line_err;
        sync_lost  = (h_cnt_nxt == CNT_MAX) || (v_cnt_nxt == CNT_MAX);
        any_err    = line_err || frame_err || sync_lost;

        frame_bad_nxt = vs_fall ? 1'b0 : (frame_bad | line_err);
    end

    always_comb begin
        state_nxt = state;
        good_nxt  = good;
        err_nxt   = 1'b0;
        case (state)
            SEARCH: begin
                if (vs_fall) begin
                    state_nxt = TRACK;
                    good_nxt  = '0;
                end
            end
            TRACK: begin
                if (frame_good) begin
                    good_nxt = good + 1'b1;
                    if ((good + 1'b1) == GW'(LOCK_FRAMES))
                        state_nxt = LOCKED;
                end else if (vs_fall) begin
                    good_nxt = '0;
                end
            end
            LOCKED: begin
                if (line_err || frame_err) begin
                    err_nxt   = 1'b1;
                    state_nxt = TRACK;
                    good_nxt  = '0;
                end
            end
            default: begin
                state_nxt = SEARCH;
                good_nxt  = '0;
            end
        endcase
        if (sync_lost) begin
            state_nxt = SEARCH;
            good_nxt  = '0;
            err_nxt   = (state == LOCKED);
        end
    end

    always_comb begin
        active_nxt      = (h_cnt_nxt >= H_ACT_LO) && (h_cnt_nxt <= H_ACT_HI) &&
                          (v_cnt_nxt >= V_ACT_LO) && (v_cnt_nxt <= V_ACT_HI) &&
                          (state_nxt == LOCKED);
        x_nxt           = active_nxt ? (h_cnt_nxt - H_ACT_LO) : 10'd0;
        y_nxt           = active_nxt ? (v_cnt_nxt - V_ACT_LO) : 10'd0;
        line_start_nxt  = hs_fall && (state == LOCKED) && !any_err;
        frame_start_nxt = vs_fall && (state == LOCKED) && !any_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= SEARCH;
            hs_q            <= 1'b1;
            vs_q            <= 1'b1;
            h_cnt           <= 10'd0;
            v_cnt           <= 10'd0;
            good            <= '0;
            frame_bad       <= 1'b0;
            vif.x           <= 10'd0;
            vif.y           <= 10'd0;
            vif.active      <= 1'b0;
            vif.line_start  <= 1'b0;
            vif.frame_start <= 1'b0;
            vif.locked      <= 1'b0;
            vif.err         <= 1'b0;
        end else begin
            state           <= state_nxt;
            hs_q            <= vif.hsync;
            vs_q            <= vif.vsync;
            h_cnt           <= h_cnt_nxt;
            v_cnt           <= v_cnt_nxt;
            good            <= good_nxt;
            frame_bad       <= frame_bad_nxt;
            vif.x           <= x_nxt;
            vif.y           <= y_nxt;
            vif.active      <= active_nxt;
            vif.line_start  <= line_start_nxt;
            vif.frame_start <= frame_start_nxt;
            vif.locked      <= (state_nxt == LOCKED);
            vif.err         <= err_nxt;
        end
    end
endmodule
